// File: rtl/param_wb_cache.sv
// param_wb_cache: direct-mapped, write-back, write-allocate cache with a
// word-serial memory port, a flush engine and saturating hit/miss counters.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cpu_rd, cpu_wr, cpu_addr,     CPU request (held while cpu_stall=1)
//   cpu_wdata, cpu_rdata,
//   cpu_stall
//   flush, flush_done             flush-all-dirty pulse / completion pulse
//   mem_req, mem_we, mem_addr,    word transfer to memory, completed by mem_ack
//   mem_wdata, mem_rdata, mem_ack
//   hit_cnt, miss_cnt             saturating statistics
module param_wb_cache #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned OFFSET_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  input  logic                flush,
  output logic                flush_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned WORDS  = 1 << OFFSET_W;
  localparam int unsigned DIDX_W = INDEX_W + OFFSET_W;
  localparam logic [OFFSET_W-1:0] LAST_WORD  = OFFSET_W'(WORDS - 1);
  localparam logic [INDEX_W-1:0]  LAST_INDEX = INDEX_W'(LINES - 1);
  localparam logic [31:0]         CNT_MAX    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, WBACK, FILL, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [OFFSET_W-1:0]  word_q, word_d;
  logic [INDEX_W-1:0]   line_q, line_d;     // line under transfer or flush scan
  logic [TAG_W-1:0]     fill_tag_q, fill_tag_d;
  logic [LINES-1:0]     valid_q, valid_d, dirty_q, dirty_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 flush_done_q, flush_done_d;
  logic [31:0]          hit_q, hit_d, miss_q, miss_d;

  // Storage arrays are never reset; valid bits qualify their contents.
  logic [DATA_W-1:0]    data_mem [LINES*WORDS];
  logic [TAG_W-1:0]     tag_mem  [LINES];

  logic                 data_we, tag_we, scan_next;
  logic [DIDX_W-1:0]    data_waddr;
  logic [DATA_W-1:0]    data_wdata;

  // CPU address fields; the byte-select bits carry no information.
  logic [OFFSET_W-1:0]  cpu_off;
  logic [INDEX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]     cpu_tag;
  logic                 unused_byte_sel;
  logic                 access, hit, line_dirty;
  logic [DIDX_W-1:0]    xfer_idx;

  assign cpu_off         = cpu_addr[OFFSET_W+1:2];
  assign cpu_idx         = cpu_addr[OFFSET_W+2 +: INDEX_W];
  assign cpu_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_byte_sel = ^cpu_addr[1:0];

  assign access     = cpu_rd | cpu_wr;
  assign hit        = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign line_dirty = valid_q[line_q] & dirty_q[line_q];
  assign xfer_idx   = {line_q, word_q};

  assign cpu_rdata  = data_mem[{cpu_idx, cpu_off}];
  assign mem_wdata  = data_mem[xfer_idx];
  assign flush_done = flush_done_q;
  assign hit_cnt    = hit_q;
  assign miss_cnt   = miss_q;

  // Next-state, array write controls and memory-port decode
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    line_d       = line_q;
    fill_tag_d   = fill_tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    flush_pend_d = flush_pend_q | flush;
    flush_done_d = 1'b0;
    hit_d        = hit_q;
    miss_d       = miss_q;
    cpu_stall    = access;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {fill_tag_q, line_q, word_q};
    data_we      = 1'b0;
    data_waddr   = xfer_idx;
    data_wdata   = mem_rdata;
    tag_we       = 1'b0;
    scan_next    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (hit) begin
            cpu_stall = 1'b0;
            if (hit_q != CNT_MAX) hit_d = hit_q + 32'd1;
            // A simultaneous rd+wr is a write.
            if (cpu_wr) begin
              data_we          = 1'b1;
              data_waddr       = {cpu_idx, cpu_off};
              data_wdata       = cpu_wdata;
              dirty_d[cpu_idx] = 1'b1;
            end
          end else begin
            if (miss_q != CNT_MAX) miss_d = miss_q + 32'd1;
            line_d     = cpu_idx;
            fill_tag_d = cpu_tag;
            word_d     = '0;
            state_d    = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? WBACK : FILL;
            // Line is invalid from here until its last fill word lands.
            valid_d[cpu_idx] = 1'b0;
            dirty_d[cpu_idx] = 1'b0;
          end
        end else if (flush_pend_q) begin
          state_d = FLUSH;
          line_d  = '0;
          word_d  = '0;
        end
      end
      WBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_mem[line_q], line_q, word_q};
        if (mem_ack) begin
          word_d = word_q + OFFSET_W'(1);
          if (word_q == LAST_WORD) state_d = FILL;
        end
      end
      FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          data_we = 1'b1;
          word_d  = word_q + OFFSET_W'(1);
          if (word_q == LAST_WORD) begin
            tag_we          = 1'b1;
            valid_d[line_q] = 1'b1;
            dirty_d[line_q] = 1'b0;
            state_d         = IDLE;
          end
        end
      end
      FLUSH: begin
        if (line_dirty) begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {tag_mem[line_q], line_q, word_q};
          if (mem_ack) begin
            word_d = word_q + OFFSET_W'(1);
            if (word_q == LAST_WORD) begin
              dirty_d[line_q] = 1'b0;
              scan_next       = 1'b1;
            end
          end
        end else begin
          scan_next = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Advance the flush scan; finishing it also swallows any pulse seen meanwhile.
    if (scan_next) begin
      if (line_q == LAST_INDEX) begin
        state_d      = IDLE;
        flush_done_d = 1'b1;
        flush_pend_d = 1'b0;
      end else begin
        line_d = line_q + INDEX_W'(1);
      end
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      line_q       <= '0;
      fill_tag_q   <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      line_q       <= line_d;
      fill_tag_q   <= fill_tag_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  // Data and tag arrays
  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (tag_we)  tag_mem[line_q]      <= fill_tag_q;
  end

endmodule

// File: tb/tb_param_wb_cache.sv
// Bench for param_wb_cache: a word memory responder with programmable ack
// latency, and a line-level cache model that predicts every memory transfer,
// read value and counter.
module tb_param_wb_cache;

  localparam int unsigned LINES = 64;
  localparam int unsigned WORDS = 8;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  param_wb_cache #(.ADDR_W(32), .DATA_W(32), .INDEX_W(6), .OFFSET_W(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .flush(flush), .flush_done(flush_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // ---------------- memory responder (environment) ----------------
  int          ack_delay  = 0;
  int          wait_cnt   = 0;
  int          unstable   = 0;
  int          req_cycles = 0;
  int          done_cnt   = 0;
  bit          have_prev  = 1'b0;
  logic        prev_we;
  logic [29:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [31:0] phys [logic [29:0]];
  xfer_t       log_q [$];

  function automatic logic [31:0] phys_rd(input logic [29:0] a);
    return phys.exists(a) ? phys[a] : 32'(a);
  endfunction

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      mem_ack   = 1'b0;
      wait_cnt  = 0;
      have_prev = 1'b0;
    end else begin
      if (flush_done === 1'b1) done_cnt++;
      if (mem_req === 1'b1) begin
        req_cycles++;
        if (have_prev && (mem_we !== prev_we || mem_addr !== prev_addr ||
                          (prev_we && mem_wdata !== prev_wdata)))
          unstable++;
        if (wait_cnt >= ack_delay) begin
          xfer_t x;
          mem_ack   = 1'b1;
          mem_rdata = phys_rd(mem_addr);
          x.we      = mem_we;
          x.addr    = mem_addr;
          x.data    = mem_we ? mem_wdata : mem_rdata;
          if (mem_we) phys[mem_addr] = mem_wdata;
          log_q.push_back(x);
          wait_cnt  = 0;
          have_prev = 1'b0;
        end else begin
          mem_ack    = 1'b0;
          wait_cnt++;
          have_prev  = 1'b1;
          prev_we    = mem_we;
          prev_addr  = mem_addr;
          prev_wdata = mem_wdata;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wait_cnt  = 0;
        have_prev = 1'b0;
      end
    end
  end

  // ---------------- line-level reference model ----------------
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  logic [20:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES][WORDS];
  logic [31:0] exp_mem [logic [29:0]];
  int unsigned exp_hits, exp_misses;
  xfer_t       exp_q [$];

  function automatic logic [31:0] exp_rd(input logic [29:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 32'(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
    exp_q.delete();
  endtask

  task automatic model_writeback(input int idx);
    xfer_t x;
    for (int w = 0; w < WORDS; w++) begin
      x.we   = 1'b1;
      x.addr = {m_tag[idx], 6'(idx), 3'(w)};
      x.data = m_data[idx][w];
      exp_mem[x.addr] = x.data;
      exp_q.push_back(x);
    end
    m_dirty[idx] = 1'b0;
  endtask

  task automatic model_access(input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata);
    int          idx, off;
    logic [20:0] tag;
    xfer_t       x;
    idx = int'(addr[10:5]);
    off = int'(addr[4:2]);
    tag = addr[31:11];
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      exp_misses++;
      if (m_valid[idx] && m_dirty[idx]) model_writeback(idx);
      for (int w = 0; w < WORDS; w++) begin
        x.we   = 1'b0;
        x.addr = {tag, 6'(idx), 3'(w)};
        x.data = exp_rd(x.addr);
        m_data[idx][w] = x.data;
        exp_q.push_back(x);
      end
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_hits++;
    if (wr) begin
      m_data[idx][off] = wdata;
      m_dirty[idx]     = 1'b1;
    end
    rdata = m_data[idx][off];
  endtask

  task automatic model_flush();
    for (int i = 0; i < LINES; i++)
      if (m_valid[i] && m_dirty[i]) model_writeback(i);
  endtask

  function automatic bit logs_match();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (log_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int count_writes();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].we) n++;
    return n;
  endfunction

  task automatic clear_logs();
    log_q.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers (no checking) ----------------
  // Called at a falling edge; returns at a falling edge after the access completed.
  task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int cycles, output bit tmo);
    cpu_rd    = !wr;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cycles    = 0;
    #1;
    while (cpu_stall === 1'b1 && cycles < 2000) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    tmo   = (cpu_stall !== 1'b0);
    rdata = cpu_rdata;
    @(negedge clk);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic pulse_flush_and_wait(input int mid_pulse_at, output bit tmo);
    int d0 = done_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      if (i == mid_pulse_at) flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    tmo = (done_cnt == d0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    clear_logs();
    #1;
    assertions++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    assertions++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    assertions++; if (flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    assertions++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    assertions++; if (hit_cnt !== 32'd0) begin failures++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
    assertions++; if (miss_cnt !== 32'd0) begin failures++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    logic [31:0] rd, exp; int cyc; bit tmo;
    ack_delay = 0;
    model_access(1'b0, 32'h0000_0040, '0, exp);
    cpu_access(1'b0, 32'h0000_0040, '0, rd, cyc, tmo);
    assertions++; if (tmo) begin failures++; $display("FAIL cold_timeout: stall never dropped"); end
    assertions++; if (rd !== 32'h10) begin failures++; $display("FAIL cold_rdata: got %h want %h", rd, 32'h10); end
    assertions++; if (cyc !== 9) begin failures++; $display("FAIL cold_stall_cycles: got %0d want 9", cyc); end
    assertions++; if (!logs_match()) begin failures++; $display("FAIL cold_transfers: got %0d xfers want %0d", log_q.size(), exp_q.size()); end
    assertions++; if (miss_cnt !== 32'd1) begin failures++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
    assertions++; if (hit_cnt !== 32'd1) begin failures++; $display("FAIL cold_hit_cnt: got %0d want 1", hit_cnt); end
    clear_logs();
  endtask

  task automatic test_write_hit();
    logic [31:0] rd, exp; int cyc, r0; bit tmo;
    r0 = req_cycles;
    model_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, exp);
    cpu_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, rd, cyc, tmo);
    assertions++; if (cyc !== 0) begin failures++; $display("FAIL wr_hit_stall: got %0d stall cycles want 0", cyc); end
    assertions++; if (req_cycles !== r0) begin failures++; $display("FAIL wr_hit_mem_req: got %0d req cycles want 0", req_cycles - r0); end
    model_access(1'b0, 32'h0000_0044, '0, exp);
    cpu_access(1'b0, 32'h0000_0044, '0, rd, cyc, tmo);
    assertions++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_hit_readback: got %h want deadbeef", rd); end
    assertions++; if (hit_cnt !== 32'd3) begin failures++; $display("FAIL wr_hit_hit_cnt: got %0d want 3", hit_cnt); end
    assertions++; if (!logs_match()) begin failures++; $display("FAIL wr_hit_transfers: got %0d xfers want %0d", log_q.size(), exp_q.size()); end
    clear_logs();
  endtask

  task automatic test_conflict_wback();
    logic [31:0] rd, exp; int cyc; bit tmo; xfer_t second;
    model_access(1'b0, 32'h0000_0840, '0, exp);
    cpu_access(1'b0, 32'h0000_0840, '0, rd, cyc, tmo);
    second = (log_q.size() > 1) ? log_q[1] : '0;
    assertions++; if (rd !== 32'h210) begin failures++; $display("FAIL conflict_rdata: got %h want 210", rd); end
    assertions++; if (second !== {1'b1, 30'h11, 32'hDEAD_BEEF}) begin failures++; $display("FAIL conflict_wb_word1: got %h want dirty word at 0x11", second); end
    assertions++; if (count_writes() !== 8) begin failures++; $display("FAIL conflict_wb_count: got %0d want 8", count_writes()); end
    assertions++; if (!logs_match()) begin failures++; $display("FAIL conflict_transfers: got %0d xfers want %0d", log_q.size(), exp_q.size()); end
    clear_logs();
  endtask

  task automatic test_slow_ack();
    logic [31:0] rd, exp; int cyc, r0; bit tmo;
    ack_delay = 3;
    unstable  = 0;
    r0        = req_cycles;
    model_access(1'b0, 32'h0000_1000, '0, exp);
    cpu_access(1'b0, 32'h0000_1000, '0, rd, cyc, tmo);
    assertions++; if (req_cycles - r0 !== 32) begin failures++; $display("FAIL slow_fill_cycles: got %0d want 32", req_cycles - r0); end
    assertions++; if (unstable !== 0) begin failures++; $display("FAIL slow_stable: got %0d changes during wait want 0", unstable); end
    assertions++; if (rd !== 32'h400) begin failures++; $display("FAIL slow_rdata: got %h want 400", rd); end
    assertions++; if (cyc !== 33) begin failures++; $display("FAIL slow_stall_cycles: got %0d want 33", cyc); end
    assertions++; if (!logs_match()) begin failures++; $display("FAIL slow_transfers: got %0d xfers want %0d", log_q.size(), exp_q.size()); end
    clear_logs();
    ack_delay = 0;
  endtask

  task automatic test_flush();
    logic [31:0] rd, exp; int cyc, d0; bit tmo;
    model_access(1'b1, 32'h0000_0840, 32'h1111_2222, exp);
    cpu_access(1'b1, 32'h0000_0840, 32'h1111_2222, rd, cyc, tmo);
    model_access(1'b1, 32'h0000_1004, 32'h3333_4444, exp);
    cpu_access(1'b1, 32'h0000_1004, 32'h3333_4444, rd, cyc, tmo);
    clear_logs();
    d0 = done_cnt;
    model_flush();
    pulse_flush_and_wait(20, tmo);
    repeat (150) @(negedge clk);
    assertions++; if (tmo) begin failures++; $display("FAIL flush_timeout: flush_done never seen"); end
    assertions++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL flush_done_pulses: got %0d want 1", done_cnt - d0); end
    assertions++; if (count_writes() !== 16) begin failures++; $display("FAIL flush_write_count: got %0d want 16", count_writes()); end
    assertions++; if (!logs_match()) begin failures++; $display("FAIL flush_transfers: got %0d xfers want %0d", log_q.size(), exp_q.size()); end
    clear_logs();
    model_access(1'b0, 32'h0000_0040, '0, exp);
    cpu_access(1'b0, 32'h0000_0040, '0, rd, cyc, tmo);
    assertions++; if (count_writes() !== 0) begin failures++; $display("FAIL flush_no_wback: got %0d writes want 0", count_writes()); end
    assertions++; if (rd !== exp) begin failures++; $display("FAIL flush_refetch_rdata: got %h want %h", rd, exp); end
    assertions++; if (!logs_match()) begin failures++; $display("FAIL flush_refetch_transfers: got %0d xfers want %0d", log_q.size(), exp_q.size()); end
    clear_logs();
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd, exp; int cyc; bit tmo, found; xfer_t first;
    ack_delay = 2;
    found     = 1'b0;
    cpu_rd    = 1'b1;
    cpu_addr  = 32'h0000_3000;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      #1;
      if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr[2:0] === 3'd4) found = 1'b1;
    end
    assertions++; if (!found) begin failures++; $display("FAIL midfill_reach_word4: fill word 4 never presented"); end
    rst = 1'b0;
    #1;
    assertions++; if (mem_req !== 1'b0) begin failures++; $display("FAIL midfill_mem_req: got %b want 0", mem_req); end
    assertions++; if (miss_cnt !== 32'd0) begin failures++; $display("FAIL midfill_cnt_clear: got %0d want 0", miss_cnt); end
    assertions++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL midfill_stall: got %b want 1", cpu_stall); end
    cpu_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    clear_logs();
    ack_delay = 0;
    model_access(1'b0, 32'h0000_3000, '0, exp);
    cpu_access(1'b0, 32'h0000_3000, '0, rd, cyc, tmo);
    first = (log_q.size() > 0) ? log_q[0] : '1;
    assertions++; if (first.addr !== 30'hC00) begin failures++; $display("FAIL midfill_refill_start: got %h want c00", first.addr); end
    assertions++; if (!logs_match()) begin failures++; $display("FAIL midfill_transfers: got %0d xfers want %0d", log_q.size(), exp_q.size()); end
    assertions++; if (rd !== 32'hC00) begin failures++; $display("FAIL midfill_rdata: got %h want c00", rd); end
    assertions++; if (miss_cnt !== 32'd1) begin failures++; $display("FAIL midfill_miss_cnt: got %0d want 1", miss_cnt); end
    clear_logs();
  endtask

  task automatic test_random();
    logic [31:0] rd, exp, addr, wd; int cyc; bit tmo, wr;
    for (int n = 0; n < 300; n++) begin
      ack_delay = int'($urandom_range(0, 2));
      wr   = 1'($urandom_range(0, 1));
      addr = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 7)) << 5) |
             (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      wd   = $urandom;
      model_access(wr, addr, wd, exp);
      cpu_access(wr, addr, wd, rd, cyc, tmo);
      assertions++; if (tmo) begin failures++; $display("FAIL rand_timeout: access %0d addr %h", n, addr); end
      if (!wr) begin
        assertions++; if (rd !== exp) begin failures++; $display("FAIL rand_rdata: access %0d addr %h got %h want %h", n, addr, rd, exp); end
      end
      assertions++; if (!logs_match()) begin failures++; $display("FAIL rand_transfers: access %0d got %0d xfers want %0d", n, log_q.size(), exp_q.size()); end
      clear_logs();
    end
    ack_delay = 1;
    model_flush();
    pulse_flush_and_wait(-1, tmo);
    assertions++; if (tmo) begin failures++; $display("FAIL rand_flush_timeout: flush_done never seen"); end
    assertions++; if (!logs_match()) begin failures++; $display("FAIL rand_flush_transfers: got %0d xfers want %0d", log_q.size(), exp_q.size()); end
    assertions++; if (hit_cnt !== exp_hits) begin failures++; $display("FAIL rand_hit_cnt: got %0d want %0d", hit_cnt, exp_hits); end
    assertions++; if (miss_cnt !== exp_misses) begin failures++; $display("FAIL rand_miss_cnt: got %0d want %0d", miss_cnt, exp_misses); end
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_conflict_wback();
    test_slow_ack();
    test_flush();
    test_reset_mid_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
